// File: rtl/riscv_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_defs (package)
//  Description : Shared opcode constants, NOP encoding and fetch-state
//                encodings for the front end of the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_defs;

    // Major opcodes consumed by control_unit
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // Bubble encoding: all-zero decodes to the control_unit default (NOP)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM encodings; 2'd3 is unused and recovers to FETCH
    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

endpackage : riscv_defs
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Bubble has priority over load;
//                with neither asserted the register holds its contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import riscv_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;

    // Bubble / load / hold selection for the decode-facing register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch with a single-outstanding req/gnt/rvalid
//                memory handshake, stall hold buffer, branch redirect with
//                in-flight response dropping, and the IF/ID register.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_defs::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [6:0]      if_id_opcode
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [XLEN-1:0] r_buf;

    logic            w_granted;
    logic            w_rsp_live;
    logic            w_load;
    logic            w_bubble;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_redirect_tgt;
    logic [XLEN-1:0] w_pc_plus4;

    // Request only from FETCH, and never while reset is held
    assign imem_req  = (r_state == c_st_fetch) && !rst;
    assign imem_addr = r_pc;
    assign w_granted = imem_req && imem_gnt;

    // Targets are forced word aligned; the increment wraps naturally
    assign w_redirect_tgt = redirect_pc & ~XLEN'(3);
    assign w_pc_plus4     = r_pc + XLEN'(4);

    // A response that is not being dropped and arrives in WAIT
    assign w_rsp_live = (r_state == c_st_wait) && imem_rvalid && !r_drop;

    // Deliver to decode either straight from memory or from the hold buffer
    assign w_load       = !redirect && !stall &&
                          (w_rsp_live || (r_state == c_st_hold));
    assign w_load_instr = (r_state == c_st_hold) ? r_buf : imem_rdata;
    assign w_bubble     = redirect || (!stall && !w_load);

    // Fetch FSM, PC, drop flag and stall hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_fetch;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_buf   <= '0;
        end else if (redirect) begin
            r_pc  <= w_redirect_tgt;
            r_buf <= '0;
            case (r_state)
                c_st_fetch: begin
                    // A request granted alongside the redirect is stale
                    r_state <= w_granted ? c_st_wait : c_st_fetch;
                    r_drop  <= w_granted;
                end
                c_st_wait: begin
                    // Response in the same cycle is consumed and dropped here
                    r_state <= imem_rvalid ? c_st_fetch : c_st_wait;
                    r_drop  <= !imem_rvalid;
                end
                default: begin
                    r_state <= c_st_fetch;
                    r_drop  <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (w_granted) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= c_st_fetch;
                        end else if (!stall) begin
                            r_pc    <= w_pc_plus4;
                            r_state <= c_st_fetch;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    if (!stall) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= c_st_fetch;
                    end
                end
                default: begin
                    r_state <= c_st_fetch;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_pc     (r_pc),
        .i_instr  (w_load_instr),
        .o_valid  (if_id_valid),
        .o_pc     (if_id_pc),
        .o_instr  (if_id_instr)
    );

    assign if_id_opcode = if_id_instr[6:0];

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed, table-driven self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic av(input logic g, input logic v, input logic [31:0] d,
                      input logic s, input logic r, input logic [31:0] rp,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic evalid, input logic [31:0] epc,
                      input logic [31:0] einstr);
        vec_t t;
        t.gnt = g; t.rvalid = v; t.rdata = d; t.stall = s;
        t.redirect = r; t.rpc = rp; t.e_req = ereq; t.e_addr = eaddr;
        t.e_valid = evalid; t.e_pc = epc; t.e_instr = einstr;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic g, input logic v, input logic [31:0] d,
                         input logic s, input logic r, input logic [31:0] rp);
        imem_gnt    = g;
        imem_rvalid = v;
        imem_rdata  = d;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
    endtask

    task automatic check(input string name, input logic ereq,
                         input logic [31:0] eaddr, input logic evalid,
                         input logic [31:0] epc, input logic [31:0] einstr);
        logic [6:0] eop;
        eop = einstr[6:0];
        n_vec++;
        if (imem_req !== ereq || imem_addr !== eaddr || if_id_valid !== evalid ||
            if_id_pc !== epc || if_id_instr !== einstr || if_id_opcode !== eop) begin
            n_bad++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h op=%b, want req=%0b addr=%h valid=%0b pc=%h instr=%h op=%b",
                     name, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
                     if_id_opcode, ereq, eaddr, evalid, epc, einstr, eop);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        //  g  v  rdata         s  r  rpc            req addr          vld pc            instr
        // Back-to-back fetches, 1 instr / 2 cycles
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
        av(0, 1, 32'h00500093, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'h00500093);
        av(0, 1, 32'h00A00113, 0, 0, 32'h0,         0, 32'h4,         0, 32'h0,         32'h0);
        // Stall covering the response: hold buffer for 3 cycles
        av(1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'h00A00113);
        av(0, 1, 32'h002081B3, 1, 0, 32'h0,         0, 32'h8,         1, 32'h4,         32'h00A00113);
        av(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h8,         1, 32'h4,         32'h00A00113);
        av(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h8,         1, 32'h4,         32'h00A00113);
        av(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h8,         1, 32'h4,         32'h00A00113);
        av(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'hC,         1, 32'h8,         32'h002081B3);
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hC,         0, 32'h0,         32'h0);
        // Redirect while WAIT, late response dropped
        av(0, 0, 32'h0,        0, 1, 32'h00000102,  0, 32'hC,         0, 32'h0,         32'h0);
        av(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        av(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0);
        av(0, 1, 32'h00412183, 0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        // Redirect + stall in HOLD: bubble, buffer discarded
        av(1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h104,       1, 32'h100,       32'h00412183);
        av(0, 1, 32'h00C0006F, 1, 0, 32'h0,         0, 32'h104,       1, 32'h100,       32'h00412183);
        av(0, 0, 32'h0,        1, 1, 32'h00000200,  0, 32'h104,       1, 32'h100,       32'h00412183);
        av(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0);
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0);
        av(0, 1, 32'h00000063, 0, 0, 32'h0,         0, 32'h200,       0, 32'h0,         32'h0);
        // PC wrap at the top of the address space
        av(0, 0, 32'h0,        0, 1, 32'hFFFFFFFC,  1, 32'h204,       1, 32'h200,       32'h00000063);
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
        av(0, 1, 32'h00208033, 0, 0, 32'h0,         0, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
        av(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,         1, 32'hFFFFFFFC,  32'h00208033);
        // Redirect on the granted cycle, then redirect coinciding with rvalid
        av(1, 0, 32'h0,        0, 1, 32'h00000300,  1, 32'h0,         0, 32'h0,         32'h0);
        av(0, 1, 32'h12345678, 0, 0, 32'h0,         0, 32'h300,       0, 32'h0,         32'h0);
        av(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h300,       0, 32'h0,         32'h0);
        av(0, 1, 32'h00000013, 0, 1, 32'h00000400,  0, 32'h300,       0, 32'h0,         32'h0);
        av(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h400,       0, 32'h0,         32'h0);

        // Reset state
        @(negedge clk);
        check("reset", 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall,
                  vecs[i].redirect, vecs[i].rpc);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                  vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
            @(posedge clk); #1;
        end

        // Asynchronous reset while a request is outstanding
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk); check("arst_f0", 1, 32'h400, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(0, 1, 32'h00500093, 0, 0, 32'h0);
        @(negedge clk); check("arst_w0", 0, 32'h400, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk); check("arst_f1", 1, 32'h404, 1, 32'h400, 32'h00500093);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check("arst_pre", 0, 32'h404, 1, 32'h400, 32'h00500093);
        rst = 1'b1;
        #1;
        check("arst_now", 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk); check("post_rst0", 1, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk); check("post_rst1", 1, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(0, 1, 32'h00A00113, 0, 0, 32'h0);
        @(negedge clk); check("post_rst2", 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk); check("post_rst3", 1, 32'h4, 1, 32'h0, 32'h00A00113);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of control_unit.
- Owns the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction, its PC and valid to decode; `if_id_opcode` drives control_unit's opcode input.
- Supports stall from hazard logic and redirect on taken branch.

Parameters:
- XLEN, 32, width of PC and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, equal to pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid, at least 1 cycle after acceptance.
- imem_rdata  in  XLEN  instruction word.
- stall  in  1  decode cannot accept a new instruction; hold IF/ID.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  XLEN  redirect target.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  XLEN  PC of the IF/ID instruction.
- if_id_instr  out  XLEN  instruction; bubble = 32'h0000_0000.
- if_id_opcode  out  7  if_id_instr[6:0], combinational.

Behaviour:
- Reset (async, rst=1) sets:
  - pc = RESET_PC, state = FETCH, drop = 0, buffer cleared.
  - if_id_valid = 0, if_id_pc = 0, if_id_instr = 0, hence if_id_opcode = 0 (control_unit default NOP).
- Reset is effective mid-transaction: outstanding response after reset release is ignored. The bench keeps rvalid low for 1 cycle after release; imem must not respond to requests issued before reset.
- imem_req = (state==FETCH) && !rst; imem_addr = pc. At most one request outstanding.
- FETCH:
  - req && gnt: go to WAIT.
  - No gnt: stay in FETCH; pc stable.
- WAIT, on rvalid:
  - drop=1: discard the data, clear drop, go to FETCH.
  - stall=0: IF/ID <= {1, pc, rdata}; pc <= pc+4; go to FETCH.
  - stall=1: latch rdata into the hold buffer; pc unchanged; go to HOLD.
- HOLD:
  - Wait for stall=0, then IF/ID <= {1, pc, buffer}; pc <= pc+4; go to FETCH.
- Stall: IF/ID retains all fields while stall=1. When no new instruction is loaded and stall=0, IF/ID takes a bubble (valid=0, instr=0, pc=0).
- Redirect (highest priority, overrides stall):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - IF/ID <= bubble; hold buffer discarded.
  - FETCH, not granted: stay in FETCH.
  - FETCH, granted same cycle: go to WAIT with drop=1.
  - WAIT: set drop=1 (or keep it); if rvalid arrives in the same cycle, drop that response and go to FETCH with drop=0.
  - HOLD: go to FETCH.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- Throughput: with gnt in the request cycle and rvalid one cycle later, 1 instruction per 2 cycles. Latency from request to if_id_valid: 2 clocks.
- States encoded 2-bit: FETCH=0, WAIT=1, HOLD=2; value 3 is illegal and recovers to FETCH.

Decomposition:
- Shared package/header riscv_defs holds:
  - Opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM.
  - NOP_INSTR = 32'h0.
  - Fetch state encodings.
- One natural sub-module: if_id_reg, the IF/ID register with load/hold/bubble control. Remaining FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after gnt, instrs 0x00500093, 0x00A00113 -> imem_addr 0x0 then 0x4; if_id_pc 0x0 then 0x4; if_id_opcode 7'b0010011 each time; valid toggles 1/0 at 2-cycle rate.
- Response arrives with stall=1 for 3 cycles, instr 0x002081B3 -> IF/ID keeps its old value for 3 cycles, then loads {1, 0x8, 0x002081B3}; no new imem_req until release.
- Redirect to 0x0000_0102 while in WAIT, later rvalid 0xDEADBEEF -> data dropped, if_id_valid=0, next imem_addr 0x0000_0100.
- Redirect and stall both high in HOLD -> IF/ID becomes bubble (opcode 0), buffer discarded, next fetch at target.
- pc preset via redirect to 0xFFFF_FFFC, one fetch completes -> if_id_pc 0xFFFF_FFFC, next imem_addr 0x0000_0000.
- rst asserted while in WAIT -> outputs go to reset values immediately (asynchronous); after release, first imem_addr = RESET_PC.
